uart_tx_sched: RTL and testbench

- Shares the single UART transmitter between two byte producers: requester 0 is the CPU IO write path, requester 1 is a secondary source such as PMU/debug status.
- Each requester has a small private FIFO. A round-robin scheduler pops one byte at a time and sequences the UART transmit/is_transmitting handshake.
- Sits in the UART clock domain, between the cross-domain bus and the UART instance.

---
 rtl/l80soc_pkg.sv | 37 +++
 rtl/tx_req_fifo.sv | 91 +++++++++
 rtl/uart_tx_sched.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l80soc_pkg.sv
// -----------------------------------------------------------------------------
// l80soc_pkg
// Shared definitions for the UART transmit scheduler:
//   - tx_state_e  : 2-bit scheduler state encoding
//   - DATA_W_DEF  : default byte width
//   - REQ_CPU / REQ_AUX : requester ids as seen on the grant output
//   - rr_pick()   : round-robin winner selection between the two requesters
// -----------------------------------------------------------------------------
package l80soc_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    // Both pending: the requester that did not win last time goes next.
    // Only one pending: that one, regardless of history.
    function automatic logic rr_pick(input logic ne0, input logic ne1, input logic last);
        logic w;
        if (ne0 && ne1) begin
            w = ~last;
        end else if (ne1) begin
            w = REQ_AUX;
        end else begin
            w = REQ_CPU;
        end
        return w;
    endfunction

endpackage

// File: rtl/tx_req_fifo.sv
// -----------------------------------------------------------------------------
// tx_req_fifo
// Small synchronous FIFO for one UART byte producer.
//   clk, rstb     : clock, asynchronous active-low reset (empties the FIFO)
//   push/push_data: write strobe and byte; accepted if not full, or if full and
//                   popped in the same cycle
//   pop/pop_data  : read strobe; pop_data shows the head entry combinationally
//   full, empty   : registered status flags
//   empty_nx      : value empty will take at the next edge (lets the parent
//                   register its own status outputs in step with the FIFO)
// -----------------------------------------------------------------------------
module tx_req_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic              empty_nx
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic [DEPTH_LOG2:0] wr_ptr_nx_s;
    logic [DEPTH_LOG2:0] rd_ptr_nx_s;
    logic                full_r;
    logic                empty_r;
    logic                full_nx_s;
    logic                empty_nx_s;
    logic                wr_en_s;
    logic                rd_en_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Accept/pop qualification and next-pointer / next-flag computation.
    // A full FIFO still takes a push when the head leaves on the same edge.
    always_comb begin
        rd_en_s     = pop && !empty_r;
        wr_en_s     = push && (!full_r || rd_en_s);
        wr_ptr_nx_s = wr_ptr_r;
        rd_ptr_nx_s = rd_ptr_r;
        if (wr_en_s) begin
            wr_ptr_nx_s = wr_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
        end else begin
            wr_ptr_nx_s = wr_ptr_r;
        end
        if (rd_en_s) begin
            rd_ptr_nx_s = rd_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
        end else begin
            rd_ptr_nx_s = rd_ptr_r;
        end
        // Full when the wrap bits differ and the index bits match.
        full_nx_s  = (wr_ptr_nx_s[DEPTH_LOG2] != rd_ptr_nx_s[DEPTH_LOG2]) &&
                     (wr_ptr_nx_s[DEPTH_LOG2-1:0] == rd_ptr_nx_s[DEPTH_LOG2-1:0]);
        empty_nx_s = (wr_ptr_nx_s == rd_ptr_nx_s);
    end

    // Pointer and status-flag registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            full_r   <= full_nx_s;
            empty_r  <= empty_nx_s;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
    assign full     = full_r;
    assign empty    = empty_r;
    assign empty_nx = empty_nx_s;

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Shares one UART transmitter between two byte producers (0 = CPU IO writes,
// 1 = auxiliary status source). Each producer has a private FIFO; a
// round-robin scheduler pops one byte at a time and runs the UART
// start / is_transmitting handshake.
//   clk, rstb             : UART-domain clock, asynchronous active-low reset
//   reqN_valid/reqN_data  : push strobe and byte from requester N
//   reqN_full             : FIFO N full
//   ovf / ovf_clr         : sticky per-requester overflow flags and their clears
//   tx_start / tx_data    : one-cycle start pulse and byte to the UART
//   tx_busy               : UART is_transmitting
//   tmo_err               : sticky, UART never reported busy after a start
//   grant                 : requester id of the current / last byte
//   idle                  : scheduler idle with both FIFOs empty
// -----------------------------------------------------------------------------
module uart_tx_sched
    import l80soc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = 2,
    parameter int BUSY_TMO   = 15
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_full,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_full,
    output logic [1:0]        ovf,
    input  logic [1:0]        ovf_clr,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic              tmo_err,
    output logic              grant,
    output logic              idle
);

    localparam int               CNT_W    = $clog2(BUSY_TMO + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TMO - 1);

    tx_state_e         state_r;
    tx_state_e         state_nx_s;
    logic [CNT_W-1:0]  tmo_cnt_r;
    logic              tmo_hit_s;
    logic              win_s;
    logic              pop0_s;
    logic              pop1_s;
    logic [1:0]        ovf_set_s;

    logic [DATA_W-1:0] rdata0_s;
    logic [DATA_W-1:0] rdata1_s;
    logic              full0_s;
    logic              full1_s;
    logic              empty0_s;
    logic              empty1_s;
    logic              empty0_nx_s;
    logic              empty1_nx_s;

    logic              tx_start_r;
    logic [DATA_W-1:0] tx_data_r;
    logic              grant_r;
    logic              tmo_err_r;
    logic              idle_r;
    logic [1:0]        ovf_r;

    tx_req_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo0 (
        .clk       (clk),
        .rstb      (rstb),
        .push      (req0_valid),
        .push_data (req0_data),
        .pop       (pop0_s),
        .pop_data  (rdata0_s),
        .full      (full0_s),
        .empty     (empty0_s),
        .empty_nx  (empty0_nx_s)
    );

    tx_req_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo1 (
        .clk       (clk),
        .rstb      (rstb),
        .push      (req1_valid),
        .push_data (req1_data),
        .pop       (pop1_s),
        .pop_data  (rdata1_s),
        .full      (full1_s),
        .empty     (empty1_s),
        .empty_nx  (empty1_nx_s)
    );

    // Next-state, pop selection and timeout detection. Pops happen only in
    // IDLE, so a byte leaves its FIFO exactly once and in FIFO order.
    always_comb begin
        state_nx_s = state_r;
        pop0_s     = 1'b0;
        pop1_s     = 1'b0;
        tmo_hit_s  = 1'b0;
        win_s      = rr_pick(!empty0_s, !empty1_s, grant_r);
        case (state_r)
            ST_IDLE: begin
                // tx_busy is deliberately not looked at here.
                if (!empty0_s || !empty1_s) begin
                    state_nx_s = ST_LAUNCH;
                    if (win_s == REQ_CPU) begin
                        pop0_s = 1'b1;
                    end else begin
                        pop1_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_nx_s = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // Busy already high on entry counts as an immediate acknowledge.
                if (tx_busy) begin
                    state_nx_s = ST_WAIT_DONE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_hit_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Overflow sets: a push that the FIFO cannot take this edge.
    always_comb begin
        ovf_set_s    = 2'b00;
        ovf_set_s[0] = req0_valid && full0_s && !pop0_s;
        ovf_set_s[1] = req1_valid && full1_s && !pop1_s;
    end

    // State register, handshake outputs and the WAIT_BUSY timeout counter.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r    <= ST_IDLE;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            grant_r    <= REQ_AUX;
            tmo_cnt_r  <= '0;
            tmo_err_r  <= 1'b0;
            idle_r     <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            // The start pulse is high for exactly the LAUNCH cycle.
            tx_start_r <= (state_nx_s == ST_LAUNCH);
            // tx_data only changes on a pop, so it holds through WAIT_DONE.
            if (pop0_s || pop1_s) begin
                tx_data_r <= pop0_s ? rdata0_s : rdata1_s;
                grant_r   <= win_s;
            end else begin
                tx_data_r <= tx_data_r;
                grant_r   <= grant_r;
            end
            if (state_r == ST_LAUNCH) begin
                tmo_cnt_r <= '0;
            end else if ((state_r == ST_WAIT_BUSY) && !tx_busy) begin
                tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
            if (tmo_hit_s) begin
                tmo_err_r <= 1'b1;
            end else begin
                tmo_err_r <= tmo_err_r;
            end
            idle_r <= (state_nx_s == ST_IDLE) && empty0_nx_s && empty1_nx_s;
        end
    end

    // Sticky overflow flags; a set on the same edge as a clear wins.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ovf_r <= 2'b00;
        end else begin
            ovf_r <= ovf_set_s | (ovf_r & ~ovf_clr);
        end
    end

    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign grant     = grant_r;
    assign tmo_err   = tmo_err_r;
    assign idle      = idle_r;
    assign ovf       = ovf_r;
    assign req0_full = full0_s;
    assign req1_full = full1_s;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
// Directed bench for uart_tx_sched (DATA_W=8, 4-entry FIFOs, BUSY_TMO=15).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

    logic       clk = 1'b0;
    logic       rstb;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_full;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_full;
    logic [1:0] ovf;
    logic [1:0] ovf_clr;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tmo_err;
    logic       grant;
    logic       idle;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .DATA_W     (8),
        .DEPTH_LOG2 (2),
        .BUSY_TMO   (15)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_full  (req0_full),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_full  (req1_full),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tmo_err    (tmo_err),
        .grant      (grant),
        .idle       (idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstb       = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        ovf_clr    = 2'b00;
        tx_busy    = 1'b0;
        tick();
        tick();
        rstb = 1'b1;
    endtask

    task automatic push(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Bounded wait for the next start pulse; lat = edges waited.
    task automatic wait_start(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while ((tx_start !== 1'b1) && (lat < 40));
    endtask

    // UART model: busy rises the cycle after start and stays up for 'hold' edges.
    task automatic complete(input string tag, input int hold);
        tx_busy = 1'b1;
        tick();
        check({tag, "_pulse_end"}, {31'd0, tx_start}, 32'd0);
        repeat (hold - 1) tick();
        tx_busy = 1'b0;
        tick();
    endtask

    task automatic serve(input string tag, input logic [7:0] d, input logic g, output int lat);
        wait_start(lat);
        check({tag, "_start"}, {31'd0, tx_start}, 32'd1);
        check({tag, "_data"}, {24'd0, tx_data}, {24'd0, d});
        check({tag, "_grant"}, {31'd0, grant}, {31'd0, g});
        complete(tag, 4);
    endtask

    initial begin
        int lat;
        int starts;

        // ---------------- reset values ----------------
        rstb       = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        ovf_clr    = 2'b00;
        tx_busy    = 1'b0;
        #12;
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_grant", {31'd0, grant}, 32'd1);
        check("rst_ovf", {30'd0, ovf}, 32'd0);
        check("rst_tmo_err", {31'd0, tmo_err}, 32'd0);
        check("rst_full0", {31'd0, req0_full}, 32'd0);
        check("rst_full1", {31'd0, req1_full}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        @(negedge clk);
        rstb = 1'b1;
        tick();

        // ---------------- 1: single byte, latency ----------------
        push(1'b1, 8'h41, 1'b0, 8'h00);           // edge k
        check("t1_k_start", {31'd0, tx_start}, 32'd0);
        check("t1_k_idle", {31'd0, idle}, 32'd0);
        tick();                                    // edge k+1
        check("t1_start", {31'd0, tx_start}, 32'd1);
        check("t1_data", {24'd0, tx_data}, 32'h41);
        check("t1_grant", {31'd0, grant}, 32'd0);
        complete("t1", 10);
        check("t1_idle", {31'd0, idle}, 32'd1);
        check("t1_data_hold", {24'd0, tx_data}, 32'h41);

        // ---------------- 2: round-robin ----------------
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h10;
        req1_valid = 1'b1; req1_data = 8'h20;
        tick();
        req0_data = 8'h11;
        req1_data = 8'h21;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("t2_b0_start", {31'd0, tx_start}, 32'd1);
        check("t2_b0_data", {24'd0, tx_data}, 32'h10);
        check("t2_b0_grant", {31'd0, grant}, 32'd0);
        complete("t2_b0", 4);
        serve("t2_b1", 8'h20, 1'b1, lat);
        check("t2_b2b_lat", lat, 32'd1);
        serve("t2_b2", 8'h11, 1'b0, lat);
        serve("t2_b3", 8'h21, 1'b1, lat);
        check("t2_idle", {31'd0, idle}, 32'd1);

        // ---------------- 3: overflow on req1 ----------------
        push(1'b1, 8'h30, 1'b0, 8'h00);
        wait_start(lat);
        check("t3_hold_data", {24'd0, tx_data}, 32'h30);
        tx_busy = 1'b1;
        tick();
        tick();                                    // now in WAIT_DONE
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = 8'hA0 + 8'(i);
            push(1'b0, 8'h00, 1'b1, d);
            if (i == 2) check("t3_full_after3", {31'd0, req1_full}, 32'd0);
        end
        check("t3_full_after4", {31'd0, req1_full}, 32'd1);
        check("t3_ovf_before", {30'd0, ovf}, 32'd0);
        ovf_clr = 2'b10;                           // clear coincides with the set
        push(1'b0, 8'h00, 1'b1, 8'hA4);
        ovf_clr = 2'b00;
        check("t3_ovf_set_wins", {30'd0, ovf}, 32'd2);
        ovf_clr = 2'b10;
        tick();
        ovf_clr = 2'b00;
        check("t3_ovf_cleared", {30'd0, ovf}, 32'd0);
        tx_busy = 1'b0;
        tick();
        serve("t3_b0", 8'hA0, 1'b1, lat);
        serve("t3_b1", 8'hA1, 1'b1, lat);
        serve("t3_b2", 8'hA2, 1'b1, lat);
        serve("t3_b3", 8'hA3, 1'b1, lat);
        check("t3_idle", {31'd0, idle}, 32'd1);
        check("t3_full_end", {31'd0, req1_full}, 32'd0);

        // ---------------- 4: busy timeout ----------------
        req0_valid = 1'b1;
        req0_data  = 8'h55;
        tick();
        req0_data  = 8'h66;
        tick();                                    // launch of 0x55
        req0_valid = 1'b0;
        check("t4_start", {31'd0, tx_start}, 32'd1);
        check("t4_data", {24'd0, tx_data}, 32'h55);
        tick();                                    // WAIT_BUSY entry
        check("t4_entry_tmo", {31'd0, tmo_err}, 32'd0);
        repeat (14) tick();
        check("t4_tmo_early", {31'd0, tmo_err}, 32'd0);
        tick();                                    // 15 cycles after entry
        check("t4_tmo_set", {31'd0, tmo_err}, 32'd1);
        check("t4_tmo_nostart", {31'd0, tx_start}, 32'd0);
        tick();
        check("t4_next_start", {31'd0, tx_start}, 32'd1);
        check("t4_next_data", {24'd0, tx_data}, 32'h66);
        complete("t4_next", 4);
        check("t4_tmo_sticky", {31'd0, tmo_err}, 32'd1);
        check("t4_idle", {31'd0, idle}, 32'd1);

        // ---------------- 5: reset during WAIT_DONE ----------------
        do_reset();
        check("t5_tmo_cleared", {31'd0, tmo_err}, 32'd0);
        push(1'b1, 8'h70, 1'b0, 8'h00);
        tick();
        check("t5_start", {31'd0, tx_start}, 32'd1);
        tx_busy = 1'b1;
        tick();
        tick();                                    // WAIT_DONE
        push(1'b1, 8'h71, 1'b0, 8'h00);
        push(1'b1, 8'h72, 1'b0, 8'h00);
        check("t5_busy_idle", {31'd0, idle}, 32'd0);
        #2;
        rstb = 1'b0;
        #1;
        check("t5_rst_start", {31'd0, tx_start}, 32'd0);
        check("t5_rst_idle", {31'd0, idle}, 32'd1);
        check("t5_rst_data", {24'd0, tx_data}, 32'd0);
        tx_busy = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        starts = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tx_start === 1'b1) starts++;
        end
        check("t5_no_launch", starts, 32'd0);
        check("t5_idle_after", {31'd0, idle}, 32'd1);

        // ---------------- 6: push into full FIFO while popping ----------------
        push(1'b1, 8'h80, 1'b0, 8'h00);
        tick();
        check("t6_start", {31'd0, tx_start}, 32'd1);
        tx_busy = 1'b1;
        tick();
        tick();                                    // WAIT_DONE
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = 8'h81 + 8'(i);
            push(1'b1, d, 1'b0, 8'h00);
        end
        check("t6_full", {31'd0, req0_full}, 32'd1);
        tx_busy = 1'b0;
        tick();                                    // back in IDLE, FIFO still full
        push(1'b1, 8'h85, 1'b0, 8'h00);            // pops 0x81 on the same edge
        check("t6_pop_start", {31'd0, tx_start}, 32'd1);
        check("t6_pop_data", {24'd0, tx_data}, 32'h81);
        check("t6_ovf0", {30'd0, ovf}, 32'd0);
        check("t6_full_again", {31'd0, req0_full}, 32'd1);
        complete("t6_b0", 4);
        serve("t6_b1", 8'h82, 1'b0, lat);
        serve("t6_b2", 8'h83, 1'b0, lat);
        serve("t6_b3", 8'h84, 1'b0, lat);
        serve("t6_b4", 8'h85, 1'b0, lat);
        check("t6_idle", {31'd0, idle}, 32'd1);
        check("t6_ovf_end", {30'd0, ovf}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
